// File: rtl/pi_pkg.sv
// Shared definitions for the Pi-to-PET SPI command register: command bit
// positions, byte-index states and frame lengths.
package pi_pkg;

  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_A16_BIT   = 0;

  localparam logic [2:0] READ_FRAME_LEN  = 3'd3;
  localparam logic [2:0] WRITE_FRAME_LEN = 3'd4;

  typedef enum logic [2:0] {
    ST_CMD     = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_DONE    = 3'd4
  } byte_state_t;

  // The byte index doubles as the byte position within the frame, so the
  // final byte is the one whose index equals the frame length minus one.
  function automatic logic is_final_byte(input byte_state_t state, input logic rw_b);
    logic [2:0] last_index;
    last_index = (rw_b ? READ_FRAME_LEN : WRITE_FRAME_LEN) - 3'd1;
    return (state == byte_state_t'(last_index));
  endfunction

  function automatic byte_state_t next_byte_state(input byte_state_t state, input logic rw_b);
    byte_state_t next;
    next = ST_DONE;
    case (state)
      ST_CMD:     next = ST_ADDR_HI;
      ST_ADDR_HI: next = ST_ADDR_LO;
      ST_ADDR_LO: next = rw_b ? ST_DONE : ST_DATA;
      default:    next = ST_DONE;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/spi_byte.sv
// SPI byte shifter: receives MSB first on spi_rx and transmits tx MSB first
// on spi_tx. The bit counter is held clear while chip select is high.
module spi_byte (
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_rx,
  output logic       spi_tx,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       done
);

  logic [2:0] count;

  always_ff @(posedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      count <= 3'd0;
    end else begin
      count <= count + 3'd1;
    end
  end

  always_ff @(posedge spi_sclk) begin
    rx <= {rx[6:0], spi_rx};
  end

  assign spi_tx = tx[3'd7 - count];
  assign done   = (count == 3'd7);

endmodule

// File: rtl/pi_spi_register.sv
// SPI-slave command register queueing one PET bus request from the Pi.
// Define PI_ADDR_A16_EN to let command bit0 drive pi_addr[16].
module pi_spi_register
  import pi_pkg::*;
(
  input  logic        spi_sclk,
  input  logic        reset_n,
  input  logic        spi_cs_n,
  input  logic        spi_rx,
  output logic [16:0] pi_addr,
  output logic [7:0]  pi_data,
  output logic        pi_rw_b,
  output logic        pi_pending
);

  byte_state_t state;
  logic        frame_started;
  logic [7:0]  rx_shift;
  logic        byte_done;
  logic        tx_bit;
  logic [7:0]  byte_now;
  logic        unused_bits;

  spi_byte u_spi_byte (
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_rx   (spi_rx),
    .spi_tx   (tx_bit),
    .tx       (8'h00),
    .rx       (rx_shift),
    .done     (byte_done)
  );

  // No clock follows the last bit, so fields are decoded from the shifter
  // contents plus the bit being sampled on the completing edge.
  assign byte_now    = {rx_shift[6:0], spi_rx};
  assign unused_bits = ^{tx_bit, rx_shift[7]};

  always_ff @(posedge spi_sclk or negedge reset_n or posedge spi_cs_n) begin
    if (!reset_n) begin
      state         <= ST_CMD;
      frame_started <= 1'b0;
    end else if (spi_cs_n) begin
      state         <= ST_CMD;
      frame_started <= 1'b0;
    end else begin
      frame_started <= 1'b1;
      if (byte_done) begin
        state <= next_byte_state(state, pi_rw_b);
      end
    end
  end

  // Pending is cleared by the first edge of a new frame; it can never be set
  // on that edge because a byte needs eight edges to complete.
  always_ff @(posedge spi_sclk or negedge reset_n) begin
    if (!reset_n) begin
      pi_addr    <= 17'd0;
      pi_data    <= 8'd0;
      pi_rw_b    <= 1'b1;
      pi_pending <= 1'b0;
    end else if (!spi_cs_n) begin
      if (!frame_started) begin
        pi_pending <= 1'b0;
      end
      if (byte_done) begin
        case (state)
          ST_CMD: begin
            pi_rw_b <= ~byte_now[CMD_WRITE_BIT];
`ifdef PI_ADDR_A16_EN
            pi_addr[16] <= byte_now[CMD_A16_BIT];
`else
            pi_addr[16] <= 1'b0;
`endif
          end
          ST_ADDR_HI: pi_addr[15:8] <= byte_now;
          ST_ADDR_LO: begin
            pi_addr[7:0] <= byte_now;
            if (is_final_byte(state, pi_rw_b)) begin
              pi_pending <= 1'b1;
            end
          end
          ST_DATA: begin
            pi_data <= byte_now;
            if (is_final_byte(state, pi_rw_b)) begin
              pi_pending <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pi_spi_register.sv
// Directed self-checking bench for pi_spi_register and the standalone
// spi_byte shifter; honours PI_ADDR_A16_EN for the expected write address.
module tb_pi_spi_register;

  logic        spi_sclk;
  logic        reset_n;
  logic        spi_cs_n;
  logic        spi_rx;
  logic [16:0] pi_addr;
  logic [7:0]  pi_data;
  logic        pi_rw_b;
  logic        pi_pending;

  logic        sb_cs_n;
  logic        sb_tx;
  logic [7:0]  sb_tx_byte;
  logic [7:0]  sb_rx;
  logic        sb_done;

  int compared;
  int mismatched;

  pi_spi_register dut (
    .spi_sclk   (spi_sclk),
    .reset_n    (reset_n),
    .spi_cs_n   (spi_cs_n),
    .spi_rx     (spi_rx),
    .pi_addr    (pi_addr),
    .pi_data    (pi_data),
    .pi_rw_b    (pi_rw_b),
    .pi_pending (pi_pending)
  );

  spi_byte u_loop (
    .spi_sclk (spi_sclk),
    .spi_cs_n (sb_cs_n),
    .spi_rx   (sb_tx),
    .spi_tx   (sb_tx),
    .tx       (sb_tx_byte),
    .rx       (sb_rx),
    .done     (sb_done)
  );

  // Comparison helper used by every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One SPI bit: data set up while the clock is low, then a full clock period
  task automatic clockBit(input logic b);
    spi_rx = b;
    #5 spi_sclk = 1'b1;
    #5 spi_sclk = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      clockBit(b[i]);
    end
  endtask

  initial begin
    logic [7:0]  wr_data;
    logic [7:0]  pattern;
    logic [16:0] wr_addr_exp;
    compared   = 0;
    mismatched = 0;
    spi_sclk   = 1'b0;
    spi_rx     = 1'b0;
    spi_cs_n   = 1'b0;
    sb_cs_n    = 1'b0;
    sb_tx_byte = 8'hA5;
    reset_n    = 1'b1;
    #1;
    spi_cs_n = 1'b1;
    sb_cs_n  = 1'b1;
    reset_n  = 1'b0;
    #10;
    checkOutput("reset_addr", 32'(pi_addr), 32'h0);
    checkOutput("reset_data", 32'(pi_data), 32'h0);
    checkOutput("reset_rw_b", 32'(pi_rw_b), 32'h1);
    checkOutput("reset_pending", 32'(pi_pending), 32'h0);
    reset_n = 1'b1;
    #10;

    // Chip select pulse with no clocks
    spi_cs_n = 1'b0;
    #10 spi_cs_n = 1'b1;
    #10;
    checkOutput("cs_pulse_addr", 32'(pi_addr), 32'h0);
    checkOutput("cs_pulse_rw_b", 32'(pi_rw_b), 32'h1);
    checkOutput("cs_pulse_pending", 32'(pi_pending), 32'h0);

    // Read frame 00 80 00
    spi_cs_n = 1'b0;
    #5;
    applyStimulus(8'h00);
    applyStimulus(8'h80);
    for (int i = 0; i < 7; i++) clockBit(1'b0);
    checkOutput("read_pending_edge23", 32'(pi_pending), 32'h0);
    clockBit(1'b0);
    checkOutput("read_pending_edge24", 32'(pi_pending), 32'h1);
    checkOutput("read_addr", 32'(pi_addr), 32'h08000);
    checkOutput("read_rw_b", 32'(pi_rw_b), 32'h1);
    spi_cs_n = 1'b1;
    #10;
    checkOutput("read_pending_held", 32'(pi_pending), 32'h1);
    checkOutput("read_addr_held", 32'(pi_addr), 32'h08000);

    // Write frame 81 E0 10 5A
`ifdef PI_ADDR_A16_EN
    wr_addr_exp = 17'h1E010;
`else
    wr_addr_exp = 17'h0E010;
`endif
    wr_data  = 8'h5A;
    pattern  = 8'h81;
    spi_cs_n = 1'b0;
    #5;
    clockBit(pattern[7]);
    checkOutput("write_pending_cleared", 32'(pi_pending), 32'h0);
    for (int i = 6; i >= 0; i--) clockBit(pattern[i]);
    checkOutput("write_rw_b", 32'(pi_rw_b), 32'h0);
    applyStimulus(8'hE0);
    applyStimulus(8'h10);
    for (int i = 7; i >= 1; i--) clockBit(wr_data[i]);
    checkOutput("write_pending_edge31", 32'(pi_pending), 32'h0);
    checkOutput("write_addr", 32'(pi_addr), 32'(wr_addr_exp));
    clockBit(wr_data[0]);
    checkOutput("write_pending_edge32", 32'(pi_pending), 32'h1);
    checkOutput("write_data", 32'(pi_data), 32'h5A);
    spi_cs_n = 1'b1;
    #10;
    checkOutput("write_pending_held", 32'(pi_pending), 32'h1);

    // Reset asserted mid-frame
    spi_cs_n = 1'b0;
    #5;
    applyStimulus(8'h81);
    applyStimulus(8'hE0);
    reset_n = 1'b0;
    #2;
    checkOutput("midreset_addr", 32'(pi_addr), 32'h0);
    checkOutput("midreset_data", 32'(pi_data), 32'h0);
    checkOutput("midreset_rw_b", 32'(pi_rw_b), 32'h1);
    checkOutput("midreset_pending", 32'(pi_pending), 32'h0);
    spi_cs_n = 1'b1;
    #5 reset_n = 1'b1;
    #10;

    // Aborted partial frame, then a complete read frame
    spi_cs_n = 1'b0;
    #5;
    applyStimulus(8'h00);
    applyStimulus(8'h12);
    spi_cs_n = 1'b1;
    #10;
    checkOutput("abort_pending", 32'(pi_pending), 32'h0);
    checkOutput("abort_addr_partial", 32'(pi_addr), 32'h01200);
    spi_cs_n = 1'b0;
    #5;
    applyStimulus(8'h00);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    checkOutput("after_abort_addr", 32'(pi_addr), 32'h03456);
    checkOutput("after_abort_pending", 32'(pi_pending), 32'h1);
    checkOutput("after_abort_rw_b", 32'(pi_rw_b), 32'h1);
    spi_cs_n = 1'b1;
    #10;

    // Standalone shifter looped back on itself with tx = A5
    sb_cs_n = 1'b0;
    #5;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("byte_tx_bit%0d", i), 32'(sb_tx), 32'(sb_tx_byte[7 - i]));
      checkOutput($sformatf("byte_done_bit%0d", i), 32'(sb_done), (i == 7) ? 32'h1 : 32'h0);
      #5 spi_sclk = 1'b1;
      #5 spi_sclk = 1'b0;
    end
    checkOutput("byte_rx_loopback", 32'(sb_rx), 32'hA5);
    checkOutput("byte_done_wrapped", 32'(sb_done), 32'h0);
    sb_cs_n = 1'b1;
    #10;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
